square_iter: RTL

SQUARE_ITER -- requirements
Module: square_iter

---
 rtl/square_iter_pkg.sv | 20 ++
 rtl/square_iter.sv | 93 +++++++++
 2 files changed

// File: rtl/square_iter_pkg.sv
// ============================================================================
// Module  : square_iter_pkg
// Brief   : Shared processing-element types and constants for square_iter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package square_iter_pkg;

    localparam int c_DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : square_iter_pkg

`default_nettype wire

// File: rtl/square_iter.sv
// ============================================================================
// Module  : square_iter
// Brief   : Iterative shift-add squarer with saturation and valid/ready I/O.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module square_iter
    import square_iter_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sq,
    output logic             ovf
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplr;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_ovf_next;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_last     = (r_state == BUSY) && (r_count == c_LAST);
    assign w_addend   = r_mplr[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_count) : '0;
    assign w_acc_next = r_acc + w_addend;
    // The last partial product must be folded in before the overflow test.
    assign w_ovf_next = |w_acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_count <= '0;
            sq      <= '0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_mplr  <= a;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == BUSY) begin
            r_acc   <= w_acc_next;
            r_mplr  <= r_mplr >> 1;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                ovf <= w_ovf_next;
                sq  <= w_ovf_next ? '1 : w_acc_next[WIDTH-1:0];
            end
        end
    end

endmodule : square_iter

`default_nettype wire
